enemy_sprite_plotter: RTL

//   Downstream of the enemy datapath. Takes one enemy's top-left origin and colour and

---
 rtl/enemy_sprite_plotter_pkg.sv | 8 +
 rtl/enemy_sprite_rom.sv | 9 +
 rtl/enemy_sprite_plotter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/enemy_sprite_plotter_pkg.sv
// enemy_sprite_plotter_pkg: sprite and screen geometry shared by the plotter and its mask ROM
package enemy_sprite_plotter_pkg;
   localparam logic [3:0] SPRITE_W = 4'd10;
   localparam logic [3:0] SPRITE_H = 4'd10;
   localparam logic [8:0] SCREEN_W = 9'd160;
   localparam logic [7:0] SCREEN_H = 8'd120;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/enemy_sprite_rom.sv
// enemy_sprite_rom: per-row sprite mask, bit c is column c; swap this module to change the sprite
module enemy_sprite_rom
   import enemy_sprite_plotter_pkg::*;
(
   input  logic [3:0] row,
   output logic [9:0] mask
);
   always_comb mask = (row == 4'd0 || row == SPRITE_H - 4'd1) ? 10'b01_1111_1110 : 10'b11_1111_1111;
endmodule

// File: rtl/enemy_sprite_plotter.sv
// enemy_sprite_plotter: rasterises a masked, screen-clipped 10x10 enemy sprite into VGA pixel writes
module enemy_sprite_plotter
   import enemy_sprite_plotter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       erase,
   input  logic [7:0] x_origin,
   input  logic [6:0] y_origin,
   input  logic [2:0] colour,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic       plot,
   output logic       busy,
   output logic       done
);
   state_t state_q, state_d;
   logic [3:0] cx_q, cx_d, cy_q, cy_d, pcx_q, pcx_d, pcy_q, pcy_d;
   logic [7:0] xo_q, xo_d, x_out_q, x_out_d;
   logic [6:0] yo_q, yo_d, y_out_q, y_out_d;
   logic [2:0] col_q, col_d, colour_out_q, colour_out_d;
   logic       er_q, er_d, run_q, run_d, pv_q, pv_d, pl_q, pl_d;
   logic       plot_q, plot_d, out_last_q, out_last_d;
   logic       col_wrap, last_px;
   logic [8:0] xs;
   logic [7:0] ys;
   logic [9:0] mask_row;

   enemy_sprite_rom u_rom (.row(pcy_q), .mask(mask_row));

   assign col_wrap = cx_q == SPRITE_W - 4'd1;
   assign last_px  = col_wrap && cy_q == SPRITE_H - 4'd1;
   assign xs = {1'b0, xo_q} + {5'd0, pcx_q};
   assign ys = {1'b0, yo_q} + {4'd0, pcy_q};

   // run_q marks cycles in which the counters issue a pixel; the FSM leaves DRAW once
   // the last pixel has reached the output registers, so done lines up with the outputs.
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      run_d   = run_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      col_d   = col_q;
      er_d    = er_q;
      if (state_q == S_IDLE && start) begin
         state_d = S_DRAW;
         xo_d    = x_origin;
         yo_d    = y_origin;
         er_d    = erase;
         col_d   = erase ? 3'b000 : colour;
         run_d   = 1'b1;
         cx_d    = 4'd0;
         cy_d    = 4'd0;
      end
      if (state_q == S_DRAW) begin
         if (run_q) begin
            cx_d  = col_wrap ? 4'd0 : cx_q + 4'd1;
            cy_d  = col_wrap ? (last_px ? 4'd0 : cy_q + 4'd1) : cy_q;
            run_d = ~last_px;
         end
         if (out_last_q) state_d = S_DONE;
      end
      if (state_q == S_DONE) state_d = S_IDLE;
   end

   always_comb begin
      pv_d         = run_q;
      pcx_d        = cx_q;
      pcy_d        = cy_q;
      pl_d         = run_q & last_px;
      x_out_d      = pv_q ? xs[7:0] : x_out_q;
      y_out_d      = pv_q ? ys[6:0] : y_out_q;
      colour_out_d = pv_q ? col_q : colour_out_q;
      plot_d       = pv_q & (er_q | mask_row[pcx_q]) & (xs < SCREEN_W) & (ys < SCREEN_H);
      out_last_d   = pl_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cx_q         <= 4'd0;
         cy_q         <= 4'd0;
         run_q        <= 1'b0;
         xo_q         <= 8'd0;
         yo_q         <= 7'd0;
         col_q        <= 3'd0;
         er_q         <= 1'b0;
         pv_q         <= 1'b0;
         pcx_q        <= 4'd0;
         pcy_q        <= 4'd0;
         pl_q         <= 1'b0;
         x_out_q      <= 8'd0;
         y_out_q      <= 7'd0;
         colour_out_q <= 3'd0;
         plot_q       <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         run_q        <= run_d;
         xo_q         <= xo_d;
         yo_q         <= yo_d;
         col_q        <= col_d;
         er_q         <= er_d;
         pv_q         <= pv_d;
         pcx_q        <= pcx_d;
         pcy_q        <= pcy_d;
         pl_q         <= pl_d;
         x_out_q      <= x_out_d;
         y_out_q      <= y_out_d;
         colour_out_q <= colour_out_d;
         plot_q       <= plot_d;
         out_last_q   <= out_last_d;
      end
   end

   assign x_out      = x_out_q;
   assign y_out      = y_out_q;
   assign colour_out = colour_out_q;
   assign plot       = plot_q;
   assign busy       = state_q == S_DRAW;
   assign done       = state_q == S_DONE;
endmodule
